// File: rtl/kernel_pkg.sv
// Shared types for the kernel window scheduler: FSM state encoding and counter widths.
// Optional feature macro used by the datapath: KERNEL_EDGE_CLAMP_EN.
package kernel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int TAP_IDX_W = 6;
    // Per-axis window counter runs 0..K-1; K is at most 7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/kernel_tap_bound.sv
// One axis of tap generation: centre + offset, bounds check and optional edge clamp.
// Define KERNEL_EDGE_CLAMP_EN to clamp the tap into [0, LIMIT-1]; otherwise the raw sum is truncated.
module kernel_tap_bound
    import kernel_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LIMIT  = 16,
    parameter int R      = 1
) (
    input  logic [ADDR_W-1:0] ctr_i,
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [ADDR_W-1:0] tap_o,
    output logic              oob_o
);

    localparam logic signed [ADDR_W:0] R_S   = (ADDR_W+1)'(R);
    localparam logic signed [ADDR_W:0] LIM_S = (ADDR_W+1)'(LIMIT);

    logic signed [ADDR_W:0] off_s;
    logic signed [ADDR_W:0] raw_s;
    logic                   under;
    logic                   over;

    // Counter 0..K-1 maps to offset -R..+R; one extra bit keeps the sum signed.
    assign off_s = $signed({{(ADDR_W+1-CNT_W){1'b0}}, cnt_i}) - R_S;
    assign raw_s = $signed({1'b0, ctr_i}) + off_s;
    assign under = raw_s[ADDR_W];
    assign over  = (raw_s >= LIM_S);
    assign oob_o = under | over;

`ifdef KERNEL_EDGE_CLAMP_EN
    assign tap_o = under ? '0 : (over ? ADDR_W'(LIMIT - 1) : raw_s[ADDR_W-1:0]);
`else
    assign tap_o = raw_s[ADDR_W-1:0];
`endif

endmodule

// File: rtl/kernel_window_scheduler.sv
// Sweeps every pixel centre in raster order and emits its KxK window taps over a valid/ready port.
// Optional edge clamping of tap coordinates is enabled by defining KERNEL_EDGE_CLAMP_EN.
module kernel_window_scheduler
    import kernel_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_D  = 16,
    parameter int K      = 3,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 tap_valid,
    input  logic                 tap_ready,
    output logic [ADDR_W-1:0]    tap_x,
    output logic [ADDR_W-1:0]    tap_y,
    output logic [ADDR_W-1:0]    ctr_x,
    output logic [ADDR_W-1:0]    ctr_y,
    output logic [TAP_IDX_W-1:0] tap_idx,
    output logic                 tap_oob,
    output logic                 tap_last,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state_o
);

    // Tap handshake: a tap transfers on a rising edge where tap_valid && tap_ready;
    // while tap_valid && !tap_ready every tap output holds. abort wins over a transfer.

    localparam int R = (K - 1) / 2;
    localparam logic [ADDR_W-1:0] LAST_X  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] LAST_Y  = ADDR_W'(IMG_D - 1);
    localparam logic [CNT_W-1:0]  LAST_DK = CNT_W'(K - 1);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      ctr_x_q, ctr_x_d;
    logic [ADDR_W-1:0]      ctr_y_q, ctr_y_d;
    logic [CNT_W-1:0]       dx_q, dx_d;
    logic [CNT_W-1:0]       dy_q, dy_d;
    logic [TAP_IDX_W-1:0]   idx_q, idx_d;

    logic                   run;
    logic                   win_last;
    logic [ADDR_W-1:0]      raw_x, raw_y;
    logic                   oob_x, oob_y;

    assign run      = (state_q == ST_RUN);
    assign win_last = (dx_q == LAST_DK) && (dy_q == LAST_DK);

    kernel_tap_bound #(.ADDR_W(ADDR_W), .LIMIT(IMG_W), .R(R)) u_bound_x (
        .ctr_i (ctr_x_q),
        .cnt_i (dx_q),
        .tap_o (raw_x),
        .oob_o (oob_x)
    );

    kernel_tap_bound #(.ADDR_W(ADDR_W), .LIMIT(IMG_D), .R(R)) u_bound_y (
        .ctr_i (ctr_y_q),
        .cnt_i (dy_q),
        .tap_o (raw_y),
        .oob_o (oob_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ctr_x_q <= '0;
            ctr_y_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_x_q <= ctr_x_d;
            ctr_y_q <= ctr_y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_x_d = ctr_x_q;
        ctr_y_d = ctr_y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    ctr_x_d = '0;
                    ctr_y_d = '0;
                    dx_d    = '0;
                    dy_d    = '0;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    ctr_x_d = '0;
                    ctr_y_d = '0;
                    dx_d    = '0;
                    dy_d    = '0;
                    idx_d   = '0;
                end else if (tap_ready) begin
                    if (win_last) begin
                        dx_d  = '0;
                        dy_d  = '0;
                        idx_d = '0;
                        if (ctr_x_q == LAST_X) begin
                            ctr_x_d = '0;
                            if (ctr_y_q == LAST_Y) begin
                                ctr_y_d = '0;
                                state_d = ST_DONE;
                            end else begin
                                ctr_y_d = ctr_y_q + 1'b1;
                            end
                        end else begin
                            ctr_x_d = ctr_x_q + 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (dx_q == LAST_DK) begin
                            dx_d = '0;
                            dy_d = dy_q + 1'b1;
                        end else begin
                            dx_d = dx_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Tap coordinate/flag outputs read as zero whenever no tap is being offered.
    assign tap_valid   = run;
    assign tap_x       = run ? raw_x : '0;
    assign tap_y       = run ? raw_y : '0;
    assign tap_oob     = run & (oob_x | oob_y);
    assign tap_last    = run & win_last;
    assign ctr_x       = ctr_x_q;
    assign ctr_y       = ctr_y_q;
    assign tap_idx     = idx_q;
    assign busy        = run;
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_kernel_window_scheduler.sv
// Randomized scoreboard bench for kernel_window_scheduler: a nested-loop model pushes every expected tap.
module tb_kernel_window_scheduler;

    localparam int IMG_W  = 16;
    localparam int IMG_D  = 16;
    localparam int K      = 3;
    localparam int ADDR_W = 8;
    localparam int R      = (K - 1) / 2;
    localparam int SWEEP  = IMG_W * IMG_D * K * K;

    typedef struct packed {
        logic [ADDR_W-1:0] tx;
        logic [ADDR_W-1:0] ty;
        logic [ADDR_W-1:0] cx;
        logic [ADDR_W-1:0] cy;
        logic [5:0]        idx;
        logic              oob;
        logic              last;
    } tap_t;
    localparam int W = $bits(tap_t);

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic              tap_valid;
    logic              tap_ready;
    logic [ADDR_W-1:0] tap_x, tap_y, ctr_x, ctr_y;
    logic [5:0]        tap_idx;
    logic              tap_oob, tap_last, busy, done;
    logic [1:0]        dbg_state_o;

    logic [W-1:0] exp_q[$];
    int           tests;
    int           fails;
    int           accepted;
    int           done_cnt;
    int           ready_mode;
    tap_t         mon_act;

    kernel_window_scheduler #(
        .IMG_W(IMG_W), .IMG_D(IMG_D), .K(K), .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .tap_valid   (tap_valid),
        .tap_ready   (tap_ready),
        .tap_x       (tap_x),
        .tap_y       (tap_y),
        .ctr_x       (ctr_x),
        .ctr_y       (ctr_y),
        .tap_idx     (tap_idx),
        .tap_oob     (tap_oob),
        .tap_last    (tap_last),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state_o)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

`ifdef KERNEL_EDGE_CLAMP_EN
    function automatic logic [ADDR_W-1:0] clampf(input int v, input int lim);
        int c;
        c = (v < 0) ? 0 : ((v >= lim) ? lim - 1 : v);
        return c[ADDR_W-1:0];
    endfunction
`endif

    // Reference model: every tap of a full sweep, in emission order.
    task automatic push_sweep();
        tap_t t;
        int   rx, ry, ix;
        for (int cy = 0; cy < IMG_D; cy++) begin
            for (int cx = 0; cx < IMG_W; cx++) begin
                for (int dy = -R; dy <= R; dy++) begin
                    for (int dx = -R; dx <= R; dx++) begin
                        rx = cx + dx;
                        ry = cy + dy;
                        ix = (dy + R) * K + (dx + R);
`ifdef KERNEL_EDGE_CLAMP_EN
                        t.tx = clampf(rx, IMG_W);
                        t.ty = clampf(ry, IMG_D);
`else
                        t.tx = rx[ADDR_W-1:0];
                        t.ty = ry[ADDR_W-1:0];
`endif
                        t.cx   = cx[ADDR_W-1:0];
                        t.cy   = cy[ADDR_W-1:0];
                        t.idx  = ix[5:0];
                        t.oob  = (rx < 0) || (rx >= IMG_W) || (ry < 0) || (ry >= IMG_D);
                        t.last = (dy == R) && (dx == R);
                        exp_q.push_back(t);
                    end
                end
            end
        end
    endtask

    // Monitor: compare presented tap with the queue head; pop on a real transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tap_valid) begin
                mon_act.tx   = tap_x;
                mon_act.ty   = tap_y;
                mon_act.cx   = ctr_x;
                mon_act.cy   = ctr_y;
                mon_act.idx  = tap_idx;
                mon_act.oob  = tap_oob;
                mon_act.last = tap_last;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_tap: got %h expected no tap", mon_act);
                end else begin
                    if (mon_act !== exp_q[0]) begin
                        fails++;
                        $display("FAIL tap: got %h expected %h", mon_act, exp_q[0]);
                    end
                    if (tap_ready && !abort) begin
                        void'(exp_q.pop_front());
                        accepted++;
                    end
                end
            end
            if (!rst && done) begin
                done_cnt++;
                tests++;
                if (exp_q.size() != 0) begin
                    fails++;
                    $display("FAIL done_early: got %0d taps pending expected 0", exp_q.size());
                end
            end
        end
    end

    // Ready driver: 0 = random, 1 = held high, 2 = left to the running test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) tap_ready = ($urandom_range(0, 3) != 0);
            else if (ready_mode == 1) tap_ready = 1'b1;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_tap_valid"}, tap_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_tap_oob"},   tap_oob,   0);
        chk({tag, "_tap_last"},  tap_last,  0);
        chk({tag, "_tap_x"},     tap_x,     0);
        chk({tag, "_tap_y"},     tap_y,     0);
        chk({tag, "_ctr_x"},     ctr_x,     0);
        chk({tag, "_ctr_y"},     ctr_y,     0);
        chk({tag, "_tap_idx"},   tap_idx,   0);
    endtask

    task automatic start_sweep();
        @(posedge clk);
        #1;
        start = 1'b1;
        push_sweep();
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("valid_after_start", tap_valid, 1);
        chk("first_idx", tap_idx, 0);
    endtask

    task automatic wait_done(output int n, input int budget);
        bit got;
        n   = 0;
        got = 0;
        while (n < budget && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
        end
        chk("done_seen", got, 1);
    endtask

    int  n;
    bit  found;
    int  saved;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        tap_ready  = 1'b0;
        ready_mode = 2;
        tests      = 0;
        fails      = 0;
        accepted   = 0;
        done_cnt   = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full sweep with ready held high: exact cycle count to done.
        ready_mode = 1;
        accepted   = 0;
        start_sweep();
        wait_done(n, 4 * SWEEP);
        chk("sweep_cycles", n, SWEEP);
        chk("sweep_accepted", accepted, SWEEP);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("busy_after_done", busy, 0);

        // Abort coincident with the first handshake at centre (3,0).
        start_sweep();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (tap_valid && tap_ready && ctr_x == 3 && ctr_y == 0) found = 1;
            else @(negedge clk);
        end
        chk("abort_point_found", found, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", tap_valid, 0);
        exp_q.delete();
        saved = done_cnt;
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", done_cnt, saved);

        // Restart from (0,0), stall four cycles on tap_idx 4, then random ready and async reset.
        ready_mode = 1;
        start_sweep();
        ready_mode = 2;
        tap_ready  = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (tap_valid && tap_idx == 3) found = 1;
            else @(negedge clk);
        end
        chk("stall_point_found", found, 1);
        @(posedge clk);
        #1;
        tap_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stall_idx", tap_idx, 4);
            @(posedge clk);
            #1;
        end
        tap_ready  = 1'b1;
        ready_mode = 0;
        repeat (300) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random-ready full sweep; start pulsed during DONE must be ignored.
        ready_mode = 0;
        accepted   = 0;
        start_sweep();
        found = 0;
        for (int i = 0; i < 6 * SWEEP && !found; i++) begin
            @(negedge clk);
            if (done) found = 1;
        end
        chk("random_sweep_done", found, 1);
        chk("random_sweep_accepted", accepted, SWEEP);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_in_done_valid", tap_valid, 0);
        chk("start_in_done_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("no_restart", tap_valid, 0);
        chk("queue_empty_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
